// File: rtl/byte_store_serializer.sv
// Little-endian store of a 32-bit value to a byte-wide memory port as 1, 2 or 4
// consecutive byte writes. Every output is driven directly from a flop.
module byte_store_serializer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Size,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic [ADDR_WIDTH-1:0] BaseAddress,
    input  logic                  Stall,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [7:0]            MemData,
    output logic                  MemCS,
    output logic                  MemWR,
    output logic                  Busy,
    output logic                  Done
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    logic                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [7:0]            byte_q,      byte_d;
    logic                  cs_n_q,      cs_n_d;
    logic                  wr_q,        wr_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic [2:0]            remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;

    always_comb begin
        // NOTE: every _d starts from its held value so no path through the case
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        byte_d      = byte_q;
        cs_n_d      = cs_n_q;
        wr_d        = wr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    data_d  = Data;
                    addr_d  = BaseAddress;
                    byte_d  = Data[7:0];
                    cs_n_d  = 1'b0;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_WRITE;
                    case (Size)
                        2'b00:   remaining_d = 3'd1;
                        2'b01:   remaining_d = 3'd2;
                        default: remaining_d = 3'd4;
                    endcase
                end
            end
            ST_WRITE: begin
                if (!Stall) begin
                    if (remaining_q == 3'd1) begin
                        cs_n_d      = 1'b1;
                        wr_d        = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = 3'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        // The latch shifts down so the next byte is always at [15:8].
                        addr_d      = addr_q + ADDR_WIDTH'(1);
                        byte_d      = data_q[15:8];
                        data_d      = data_q >> 8;
                        remaining_d = remaining_q - 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            // NOTE: the data latch is reset too; it is a handful of flops, not a
            // memory array, and a known value keeps MemData deterministic.
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            byte_q      <= '0;
            cs_n_q      <= 1'b1;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            data_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            cs_n_q      <= cs_n_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
        end
    end

    assign MemAddress = addr_q;
    assign MemData    = byte_q;
    assign MemCS      = cs_n_q;
    assign MemWR      = wr_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule
